dmem_ctl: RTL
=============

Name: dmem_ctl

Overview:
- Memory-access stage control between the EX/MEM pipeline register and the dual-port byte-lane data/instruction RAM.
- Converts load/store requests into per-byte write enables, lane-replicated write data and a word address. Stores are big-endian: byte offset 0 maps to bits 31:24.
- The RAM read port is synchronous, so the block registers load context and returns sign- or zero-extended load data exactly one cycle after the request.
- Detects misaligned accesses and raises an address exception to the pipeline.

Parameters:
- ADDR_W, 32, byte address width presented by the pipeline.
- DEF_LD, 32'h0000_0000, value held on ld_data after reset.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  a memory operation is presented this cycle.
- req_op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_wren  out  4  byte write enables to RAM lanes [3]=31:24 … [0]=7:0.
- mem_din  out  32  lane-replicated store data to RAM.
- mem_addr  out  ADDR_W  byte address to RAM; low 2 bits are don't-care to RAM.
- mem_dout  in  32  RAM read word, valid one cycle after the address.
- ld_valid  out  1  ld_data is valid this cycle.
- ld_data  out  32  extended load result.
- exc_pulse  out  1  one-cycle misaligned-access exception.
- exc_addr  out  ADDR_W  offending address of the last exception.

Behaviour:
- Request path is combinational. mem_addr = req_addr whenever req_valid; otherwise it holds its last value via a register. mem_wren = 0 unless req_valid and a store op; mem_wren is forced 0 while rst=1.
- Store lanes:
  - SB: mem_din = {4{b}}; mem_wren = 4'b1000 >> addr[1:0].
  - SH: mem_din = {2{h}}; mem_wren = 1100 if addr[1]=0, else 0011.
  - SW: mem_din = wdata; mem_wren = 1111.
- Misaligned definition: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. A misaligned store drives mem_wren=0; a misaligned load produces no ld_valid.
- Load tracking FSM: states IDLE and RESP.
  - IDLE→RESP on an aligned load request; the op and addr[1:0] are latched.
  - RESP: ld_valid=1 for exactly that cycle. ld_data is extracted from mem_dout using the latched offset (byte lane 31:24 for offset 0, and so on; halfword 31:16 for offset 0) and sign-extended for LB/LH, zero-extended for LBU/LHU.
  - RESP→RESP if another aligned load arrives in the same cycle (back-to-back, full throughput). RESP→IDLE otherwise.
- ld_data is held between responses; it resets to DEF_LD.
- exc_pulse is registered: high the cycle after a misaligned request. exc_addr captures req_addr on the same edge and holds until the next exception.
- Store followed by a load to the same word on the next cycle returns the stored data; this relies on RAM write-then-read ordering and needs no bypass in this block.
- Reset values: state=IDLE, ld_valid=0, ld_data=DEF_LD, exc_pulse=0, exc_addr=0, held mem_addr=0.
- Reset asserted mid-load (in RESP) aborts the response: no ld_valid in the following cycle.
- req_valid=0: no wren, no state advance except RESP→IDLE.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misalignment detection, exception and suppression exactly as above.
- Undefined: no exception logic; exc_pulse and exc_addr are tied 0. Misaligned accesses are force-aligned by ignoring addr[0] (half) or addr[1:0] (word), then executed normally.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=1, SW → mem_wren=0 throughout; after release ld_valid=0, ld_data=0, exc_pulse=0.
- SB 0x5A @0x103 → mem_wren=0001, mem_din=5A5A5A5A. Then LB @0x103 → next cycle ld_valid=1, ld_data=0000005A. LB of 0x80 at offset 0 → FFFFFF80.
- SH 0xBEEF @0x202 → mem_wren=0011. LHU @0x202 → ld_data=0000BEEF. LH @0x202 → FFFFBEEF.
- Back-to-back LW @0x0, LW @0x4, LW @0x8 with RAM words 11111111/22222222/33333333 → ld_valid high 3 consecutive cycles with those values in order.
- With trap enabled, SW @0x301 → mem_wren=0, exc_pulse=1 next cycle, exc_addr=0x301. LH @0x401 → no ld_valid, exc_addr=0x401. With the macro undefined, SW @0x301 writes word 0x300 with wren=1111.
- Reset asserted in the cycle after LW @0x10 → no ld_valid; FSM returns to IDLE.

Source files
------------

// File: rtl/dmem_ctl.sv
// Memory-stage control: turns load/store requests into byte-lane RAM writes and
// extends synchronous RAM read data. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module dmem_ctl #(
   parameter int          ADDR_W = 32,
   parameter logic [31:0] DEF_LD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic [3:0]        mem_wren,
   output logic [31:0]       mem_din,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_dout,
   output logic              ld_valid,
   output logic [31:0]       ld_data,
   output logic              exc_pulse,
   output logic [ADDR_W-1:0] exc_addr
);

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LH  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   typedef enum logic {IDLE, RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       ld_hold_q, ld_hold_d;

   logic       is_load, mis_raw, mis, ld_go;
   logic [1:0] off;
   logic [7:0] byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext;

   // Offset is always size-aligned; with the trap enabled the misaligned
   // request is suppressed anyway, so one path serves both builds.
   always_comb begin
      is_load = (req_op <= OP_LW);
      mis_raw = 1'b0;
      off     = req_addr[1:0];
      case (req_op)
         OP_LH, OP_LHU, OP_SH: begin
            mis_raw = req_addr[0];
            off     = {req_addr[1], 1'b0};
         end
         OP_LW, OP_SW: begin
            mis_raw = |req_addr[1:0];
            off     = 2'b00;
         end
         default: ;
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      mis = mis_raw;
`else
      mis = 1'b0;
`endif
      ld_go = req_valid && is_load && !mis;
   end

   always_comb begin
      mem_din  = req_wdata;
      mem_wren = 4'b0000;
      case (req_op)
         OP_SB: begin
            mem_din  = {4{req_wdata[7:0]}};
            mem_wren = 4'b1000 >> off;
         end
         OP_SH: begin
            mem_din  = {2{req_wdata[15:0]}};
            mem_wren = off[1] ? 4'b0011 : 4'b1100;
         end
         OP_SW: mem_wren = 4'b1111;
         default: ;
      endcase
      if (!req_valid || mis || rst)
         mem_wren = 4'b0000;
      addr_d   = req_valid ? req_addr : addr_q;
      mem_addr = addr_d;
   end

   // Big-endian lane extraction from the word returned this cycle.
   always_comb begin
      case (off_q)
         2'd0:    byte_sel = mem_dout[31:24];
         2'd1:    byte_sel = mem_dout[23:16];
         2'd2:    byte_sel = mem_dout[15:8];
         default: byte_sel = mem_dout[7:0];
      endcase
      half_sel = off_q[1] ? mem_dout[15:0] : mem_dout[31:16];
      case (op_q)
         OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  ext = {24'd0, byte_sel};
         OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  ext = {16'd0, half_sel};
         default: ext = mem_dout;
      endcase
   end

   // Reset during RESP kills the response in that same cycle.
   always_comb begin
      state_d   = ld_go ? RESP : IDLE;
      op_d      = ld_go ? req_op : op_q;
      off_d     = ld_go ? off : off_q;
      ld_valid  = (state_q == RESP) && !rst;
      ld_hold_d = ld_valid ? ext : ld_hold_q;
      ld_data   = ld_hold_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_LW;
         off_q     <= 2'b00;
         addr_q    <= '0;
         ld_hold_q <= DEF_LD;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         ld_hold_q <= ld_hold_d;
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic              exc_pulse_q, exc_pulse_d;
   logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

   always_comb begin
      exc_pulse_d = req_valid && mis;
      exc_addr_d  = exc_pulse_d ? req_addr : exc_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exc_pulse_q <= 1'b0;
         exc_addr_q  <= '0;
      end else begin
         exc_pulse_q <= exc_pulse_d;
         exc_addr_q  <= exc_addr_d;
      end
   end

   assign exc_pulse = exc_pulse_q;
   assign exc_addr  = exc_addr_q;
`else
   logic unused_mis;
   assign unused_mis = mis_raw;
   assign exc_pulse  = 1'b0;
   assign exc_addr   = '0;
`endif

endmodule
